uart_rtx_param: RTL

Parametrised full-duplex UART transceiver. It replaces the fixed 9600-baud, 8N1 RX/TX controller pair with a single block that has:
- configurable bit period, data width and stop bits;
- optional parity;
- valid/ready handshakes on both sides;
- a synchronised RX input with framing and overrun reporting.

It sits between the Bluetooth module's UART pins and the command/response logic.

---
 rtl/uart_rtx_param.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rtx_param.sv
// Parametrised full-duplex UART: start bit, DATA_BITS LSB first, optional parity, stop bit(s).
// Define UART_RTX_PARITY_EN to insert/check a parity bit (PARITY_ODD selects odd parity).
module uart_rtx_param #(
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 uart_tx,
   input  logic                 uart_rx,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]      BitLast  = 3'(DATA_BITS - 1);
   localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RTX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // ---------------- transmitter ----------------
   state_e                tx_state_q;
   logic [CntW-1:0]       tx_cnt_q;
   logic [2:0]            tx_bit_q;
   logic [DATA_BITS-1:0]  tx_shift_q;
   logic                  tx_q;
   logic                  tx_ready_q;
   logic                  tx_tick;
`ifdef UART_RTX_PARITY_EN
   logic                  tx_par_q;
`endif

   assign tx_tick = (tx_cnt_q == CntLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= StIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
`ifdef UART_RTX_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         if (tx_state_q != StIdle) tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
         unique case (tx_state_q)
            StIdle: if (tx_valid) begin
               tx_shift_q <= tx_data;
`ifdef UART_RTX_PARITY_EN
               tx_par_q   <= ^tx_data ^ PARITY_ODD;
`endif
               tx_cnt_q   <= '0;
               tx_q       <= 1'b0;
               tx_ready_q <= 1'b0;
               tx_state_q <= StStart;
            end
            StStart: if (tx_tick) begin
               tx_q       <= tx_shift_q[0];
               tx_bit_q   <= '0;
               tx_state_q <= StData;
            end
            StData: if (tx_tick) begin
               if (tx_bit_q == BitLast) begin
                  tx_bit_q   <= '0;
`ifdef UART_RTX_PARITY_EN
                  tx_q       <= tx_par_q;
                  tx_state_q <= StParity;
`else
                  tx_q       <= 1'b1;
                  tx_state_q <= StStop;
`endif
               end else begin
                  tx_q       <= tx_shift_q[1];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_bit_q   <= tx_bit_q + 1'b1;
               end
            end
`ifdef UART_RTX_PARITY_EN
            StParity: if (tx_tick) begin
               tx_q       <= 1'b1;
               tx_state_q <= StStop;
            end
`endif
            // tx_bit_q counts stop-bit periods here
            StStop: if (tx_tick) begin
               if (tx_bit_q == StopLast) begin
                  tx_ready_q <= 1'b1;
                  tx_state_q <= StIdle;
               end else begin
                  tx_bit_q <= tx_bit_q + 1'b1;
               end
            end
            default: tx_state_q <= StIdle;
         endcase
      end
   end

   assign tx_ready = tx_ready_q;
   assign uart_tx  = tx_q;

   // ---------------- receiver ----------------
   logic                  rx_meta_q;
   logic                  rx_s_q;
   state_e                rx_state_q;
   logic [CntW-1:0]       rx_cnt_q;
   logic [2:0]            rx_bit_q;
   logic [DATA_BITS-1:0]  rx_shift_q;
   logic                  rx_valid_q;
   logic [DATA_BITS-1:0]  rx_data_q;
   logic                  rx_ferr_q;
   logic                  rx_ovr_q;
   logic                  rx_tick;
`ifdef UART_RTX_PARITY_EN
   logic                  rx_par_q;
   logic                  rx_perr_q;
`endif

   assign rx_tick = (rx_cnt_q == CntLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_state_q <= StIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
`ifdef UART_RTX_PARITY_EN
         rx_par_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rx_meta_q <= uart_rx;
         rx_s_q    <= rx_meta_q;
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
         end
         if (rx_state_q != StIdle && rx_state_q != StStart) begin
            rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 1'b1;
         end
         unique case (rx_state_q)
            StIdle: if (!rx_s_q) begin
               rx_cnt_q   <= '0;
               rx_state_q <= StStart;
            end
            // Half-bit check rejects glitches and aligns later samples to mid-bit
            StStart: if (rx_cnt_q == CntHalf) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_s_q ? StIdle : StData;
            end else begin
               rx_cnt_q <= rx_cnt_q + 1'b1;
            end
            StData: if (rx_tick) begin
               rx_shift_q <= {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BitLast) begin
`ifdef UART_RTX_PARITY_EN
                  rx_state_q <= StParity;
`else
                  rx_state_q <= StStop;
`endif
               end else begin
                  rx_bit_q <= rx_bit_q + 1'b1;
               end
            end
`ifdef UART_RTX_PARITY_EN
            StParity: if (rx_tick) begin
               rx_par_q   <= rx_s_q;
               rx_state_q <= StStop;
            end
`endif
            StStop: if (rx_tick) begin
               rx_state_q <= StIdle;
               if (!rx_valid_q || rx_ready) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_shift_q;
                  rx_ferr_q  <= !rx_s_q;
                  rx_ovr_q   <= 1'b0;
`ifdef UART_RTX_PARITY_EN
                  rx_perr_q  <= rx_par_q ^ (^rx_shift_q) ^ PARITY_ODD;
`endif
               end else begin
                  rx_ovr_q <= 1'b1;
               end
            end
            default: rx_state_q <= StIdle;
         endcase
      end
   end

   assign rx_valid     = rx_valid_q;
   assign rx_data      = rx_data_q;
   assign rx_frame_err = rx_ferr_q;
   assign rx_overrun   = rx_ovr_q;
`ifdef UART_RTX_PARITY_EN
   assign rx_parity_err = rx_perr_q;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
   assign rx_parity_err     = 1'b0;
`endif

endmodule
